bus_master_interface: RTL and testbench

Initiator end of the system memory-mapped bus: accepts one load/store request at a time from a client, such as the CPU load/store unit or a future DMA engine. It drives `addr_bus`, `data_bus`, `rd_bus`, `wr_bus` and `data_mask_bus`, and waits for a responder to raise `fc_bus`. It returns read data or an error (misaligned access, or no responder within a timeout) to the client. It is the counterpart of every device bus interface (SSDs, UART, timers) attached to the same bus.

---
 rtl/bus_master_interface_pkg.sv | 32 +++
 rtl/bus_master_interface_if.sv | 33 +++
 rtl/bus_lane_formatter.sv | 28 ++
 rtl/bus_master_interface.sv | 150 +++++++++++++++
 tb/tb_bus_master_interface.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_master_interface_pkg.sv
// Shared bus definitions: size codes, bus width and the size-to-byte-mask helper.
// Device-side bus interfaces import this package as well.
package bus_master_interface_pkg;

  localparam int unsigned BusWidth = 32;
  localparam int unsigned BusBytes = BusWidth / 8;

  typedef enum logic [1:0] {
    BusSizeByte = 2'd0,
    BusSizeHalf = 2'd1,
    BusSizeWord = 2'd2,
    BusSizeRsvd = 2'd3
  } bus_size_e;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRelease
  } bmi_state_e;

  // Right-aligned byte enables; the reserved code behaves as a word.
  function automatic logic [BusBytes-1:0] size_to_mask(input logic [1:0] size);
    logic [BusBytes-1:0] m;
    case (size)
      BusSizeByte: m = 4'b0001;
      BusSizeHalf: m = 4'b0011;
      default:     m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bus_master_interface_if.sv
// Client request/response and memory-bus control signals of the bus initiator.
// The shared data lines are a tristate net and are carried as a separate port.
interface bus_master_interface_if;
  import bus_master_interface_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_wr;
  logic [BusWidth-1:0] req_addr;
  logic [1:0]          req_size;
  logic [BusWidth-1:0] req_wdata;
  logic                resp_valid;
  logic                resp_err;
  logic [BusWidth-1:0] resp_rdata;
  logic [BusWidth-1:0] addr_bus;
  logic                rd_bus;
  logic                wr_bus;
  logic [BusBytes-1:0] data_mask_bus;
  logic                fc_bus;

  modport master (
    input  req_valid, req_wr, req_addr, req_size, req_wdata, fc_bus,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output addr_bus, rd_bus, wr_bus, data_mask_bus
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_size, req_wdata, fc_bus,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  addr_bus, rd_bus, wr_bus, data_mask_bus
  );

endinterface

// File: rtl/bus_lane_formatter.sv
// Combinational lane formatting: size to byte mask, read-data masking and
// misalignment detection for right-aligned transfers.
module bus_lane_formatter
  import bus_master_interface_pkg::*;
(
  input  logic [1:0]          size_i,
  input  logic [1:0]          addr_lsb_i,
  input  logic [BusWidth-1:0] rdata_i,
  output logic [BusBytes-1:0] mask_o,
  output logic [BusWidth-1:0] rdata_o,
  output logic                misaligned_o
);

  always_comb begin
    mask_o       = size_to_mask(size_i);
    rdata_o      = '0;
    misaligned_o = 1'b0;
    for (int i = 0; i < int'(BusBytes); i++) begin
      rdata_o[8*i +: 8] = mask_o[i] ? rdata_i[8*i +: 8] : 8'h00;
    end
    case (size_i)
      BusSizeByte: misaligned_o = 1'b0;
      BusSizeHalf: misaligned_o = addr_lsb_i[0];
      default:     misaligned_o = |addr_lsb_i;
    endcase
  end

endmodule

// File: rtl/bus_master_interface.sv
// Bus initiator: accepts one client load/store at a time, runs it on the shared
// bus with a completion timeout, and returns data or an error to the client.
module bus_master_interface
  import bus_master_interface_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bus_master_interface_if.master bus,
  inout  wire  [BusWidth-1:0]   data_bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  bmi_state_e          state_q, state_d;
  logic [BusWidth-1:0] addr_q, addr_d;
  logic [BusBytes-1:0] mask_q, mask_d;
  logic [1:0]          size_q, size_d;
  logic                is_wr_q, is_wr_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [BusWidth-1:0] wdata_q, wdata_d;
  logic [BusWidth-1:0] rdata_q, rdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CntW-1:0]     cnt_inc;

  logic [1:0]          fmt_size;
  logic [BusBytes-1:0] fmt_mask;
  logic [BusWidth-1:0] fmt_rdata;
  logic                fmt_misaligned;

  // In IDLE the formatter checks the incoming request; otherwise it masks bus data.
  assign fmt_size = (state_q == StIdle) ? bus.req_size : size_q;

  bus_lane_formatter u_fmt (
    .size_i       (fmt_size),
    .addr_lsb_i   (bus.req_addr[1:0]),
    .rdata_i      (data_bus),
    .mask_o       (fmt_mask),
    .rdata_o      (fmt_rdata),
    .misaligned_o (fmt_misaligned)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    mask_d       = mask_q;
    size_d       = size_q;
    is_wr_d      = is_wr_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    cnt_d        = cnt_q;
    cnt_inc      = cnt_q + CntW'(1);

    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          size_d  = bus.req_size;
          mask_d  = fmt_mask;
          is_wr_d = bus.req_wr;
          wdata_d = bus.req_wdata;
          cnt_d   = '0;
          if (fmt_misaligned) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            rdata_d      = '0;
            state_d      = StRelease;
          end else begin
            rd_d    = ~bus.req_wr;
            wr_d    = bus.req_wr;
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        // Completion is tested first so fc on the timeout edge still succeeds.
        if (bus.fc_bus) begin
          resp_valid_d = 1'b1;
          rdata_d      = is_wr_q ? '0 : fmt_rdata;
          rd_d         = 1'b0;
          wr_d         = 1'b0;
          state_d      = StRelease;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntW'(TIMEOUT)) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            rdata_d      = '0;
            rd_d         = 1'b0;
            wr_d         = 1'b0;
            state_d      = StRelease;
          end
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      mask_q       <= '0;
      size_q       <= '0;
      is_wr_q      <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      mask_q       <= mask_d;
      size_q       <= size_d;
      is_wr_q      <= is_wr_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Driven straight from the registered write strobe so reset releases it at once.
  assign data_bus = wr_q ? wdata_q : {BusWidth{1'bz}};

  assign bus.req_ready     = (state_q == StIdle);
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.resp_rdata    = rdata_q;
  assign bus.addr_bus      = addr_q;
  assign bus.rd_bus        = rd_q;
  assign bus.wr_bus        = wr_q;
  assign bus.data_mask_bus = mask_q;

endmodule

// File: tb/tb_bus_master_interface.sv
// Directed bench for bus_master_interface: a vector table of single transactions
// against a small responder, plus back-to-back and mid-access reset sequences.
module tb_bus_master_interface;

  localparam int unsigned Timeout = 16;

  logic        clk;
  logic        rst_n;
  wire  [31:0] data_bus;

  bus_master_interface_if bif ();

  bus_master_interface #(.TIMEOUT(Timeout)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bif),
    .data_bus (data_bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    int          fc_at;   // strobe cycle in which fc rises; 0 = never
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  mask;
    int          lat;     // cycle after accept in which resp_valid is high
  } vec_t;

  vec_t        vecs[15];
  int          n_vec;
  int          n_bad;
  int          fc_at_cur;
  logic        force_en;
  logic [31:0] force_val;
  logic [31:0] mem[16];
  int          strobe_run;
  logic        tb_en;
  logic [31:0] tb_val;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Responder: word memory indexed by addr[5:2], fc after a programmable delay.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_run <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h11223344;
      mem[1] <= 32'hDEADBEEF;
      mem[2] <= 32'hCAFEF00D;
    end else begin
      strobe_run <= (bif.rd_bus || bif.wr_bus) ? strobe_run + 1 : 0;
      if (bif.wr_bus && bif.fc_bus) begin
        for (int b = 0; b < 4; b++) begin
          if (bif.data_mask_bus[b]) mem[bif.addr_bus[5:2]][8*b +: 8] <= data_bus[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    bif.fc_bus = (bif.rd_bus || bif.wr_bus) && (fc_at_cur != 0) && (strobe_run + 1 == fc_at_cur);
    tb_en      = force_en || bif.rd_bus;
    tb_val     = force_en ? force_val : mem[bif.addr_bus[5:2]];
  end

  assign data_bus = tb_en ? tb_val : 32'hzzzz_zzzz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bif.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bif.req_ready) check("ready_wait", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input int i);
    vec_t        v;
    int          lat;
    int          strobes;
    logic        bad_strobe;
    logic        data_ok;
    logic [3:0]  mask_seen;
    v = vecs[i];
    wait_ready();
    fc_at_cur      = v.fc_at;
    bif.req_wr     = v.wr;
    bif.req_addr   = v.addr;
    bif.req_size   = v.size;
    bif.req_wdata  = v.wdata;
    bif.req_valid  = 1'b1;
    @(posedge clk);
    #1 bif.req_valid = 1'b0;
    lat = 0; strobes = 0; bad_strobe = 1'b0; data_ok = 1'b1; mask_seen = 4'h0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      if (bif.rd_bus && bif.wr_bus) bad_strobe = 1'b1;
      if (v.wr ? bif.rd_bus : bif.wr_bus) bad_strobe = 1'b1;
      if (v.wr ? bif.wr_bus : bif.rd_bus) begin
        strobes++;
        mask_seen = bif.data_mask_bus;
      end
      if (bif.wr_bus && data_bus !== v.wdata) data_ok = 1'b0;
      if (bif.resp_valid) lat = c;
    end
    check($sformatf("v%0d latency", i), 32'(lat), 32'(v.lat));
    check($sformatf("v%0d resp_err", i), {31'b0, bif.resp_err}, {31'b0, v.err});
    check($sformatf("v%0d resp_rdata", i), bif.resp_rdata, v.rdata);
    check($sformatf("v%0d strobe_cycles", i), 32'(strobes), 32'(v.lat - 1));
    check($sformatf("v%0d strobe_kind", i), {31'b0, bad_strobe}, 32'd0);
    if (v.lat > 1) check($sformatf("v%0d mask", i), {28'b0, mask_seen}, {28'b0, v.mask});
    if (v.wr && v.lat > 1) check($sformatf("v%0d wdata_on_bus", i), {31'b0, data_ok}, 32'd1);
    if (lat != 0) begin
      force_en  = 1'b1;
      force_val = 32'h12345600;
      #1;
      check($sformatf("v%0d release_bus_z", i), data_bus, 32'h12345600);
      check($sformatf("v%0d release_strobes", i), {30'b0, bif.rd_bus, bif.wr_bus}, 32'd0);
      force_en = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d ready_after", i), {30'b0, bif.req_ready, bif.resp_valid}, 32'd2);
    end
  endtask

  initial begin
    logic wr_seen, gap_seen, rd_seen, order_bad;
    int   n_resp;
    logic [31:0] rd_result;
    logic        rd_err;

    n_vec = 0; n_bad = 0; fc_at_cur = 0;
    force_en = 1'b0; force_val = 32'h0;
    bif.req_valid = 1'b0; bif.req_wr = 1'b0; bif.req_addr = 32'h0;
    bif.req_size = 2'd0; bif.req_wdata = 32'h0;
    rst_n = 1'b0;

    //          wr    addr         sz     wdata         fc  err   rdata         mask lat
    vecs[0]  = '{1'b0, 32'h1004, 2'd2, 32'h0,        1,  1'b0, 32'hDEADBEEF, 4'hF, 2};
    vecs[1]  = '{1'b1, 32'h2003, 2'd0, 32'h000000A5, 2,  1'b0, 32'h0,        4'h1, 3};
    vecs[2]  = '{1'b0, 32'h2003, 2'd0, 32'h0,        1,  1'b0, 32'h000000A5, 4'h1, 2};
    vecs[3]  = '{1'b0, 32'h2002, 2'd1, 32'h0,        1,  1'b0, 32'h000033A5, 4'h3, 2};
    vecs[4]  = '{1'b0, 32'h2000, 2'd2, 32'h0,        2,  1'b0, 32'h112233A5, 4'hF, 3};
    vecs[5]  = '{1'b0, 32'h3001, 2'd1, 32'h0,        1,  1'b1, 32'h0,        4'h0, 1};
    vecs[6]  = '{1'b1, 32'h1002, 2'd2, 32'h55555555, 1,  1'b1, 32'h0,        4'h0, 1};
    vecs[7]  = '{1'b0, 32'h1004, 2'd3, 32'h0,        1,  1'b0, 32'hDEADBEEF, 4'hF, 2};
    vecs[8]  = '{1'b0, 32'h1008, 2'd2, 32'h0,        2,  1'b0, 32'hCAFEF00D, 4'hF, 3};
    vecs[9]  = '{1'b0, 32'h4000, 2'd2, 32'h0,        0,  1'b1, 32'h0,        4'hF, 17};
    vecs[10] = '{1'b1, 32'h1010, 2'd2, 32'h12345678, 1,  1'b0, 32'h0,        4'hF, 2};
    vecs[11] = '{1'b0, 32'h1010, 2'd1, 32'h0,        2,  1'b0, 32'h00005678, 4'h3, 3};
    vecs[12] = '{1'b0, 32'h1004, 2'd2, 32'h0,        16, 1'b0, 32'hDEADBEEF, 4'hF, 17};
    vecs[13] = '{1'b0, 32'h1007, 2'd0, 32'h0,        17, 1'b1, 32'h0,        4'h1, 17};
    vecs[14] = '{1'b1, 32'h2002, 2'd1, 32'h0000BEEF, 1,  1'b0, 32'h0,        4'h3, 2};

    repeat (2) @(negedge clk);
    check("reset_ready", {31'b0, bif.req_ready}, 32'd1);
    check("reset_strobes", {30'b0, bif.rd_bus, bif.wr_bus}, 32'd0);
    check("reset_resp", {30'b0, bif.resp_valid, bif.resp_err}, 32'd0);
    check("reset_addr", bif.addr_bus, 32'd0);
    check("reset_mask", {28'b0, bif.data_mask_bus}, 32'd0);
    check("reset_rdata", bif.resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) run_vec(i);

    // Back-to-back write then read with req_valid held high throughout.
    wait_ready();
    fc_at_cur = 2;
    bif.req_wr = 1'b1; bif.req_addr = 32'h1020; bif.req_size = 2'd2;
    bif.req_wdata = 32'hBEEF0001; bif.req_valid = 1'b1;
    @(posedge clk);
    #1 bif.req_wr = 1'b0;
    wr_seen = 1'b0; gap_seen = 1'b0; rd_seen = 1'b0; order_bad = 1'b0;
    n_resp = 0; rd_result = 32'h0; rd_err = 1'b1;
    for (int c = 1; c <= 40 && n_resp < 2; c++) begin
      @(negedge clk);
      if (bif.wr_bus) wr_seen = 1'b1;
      if (wr_seen && !bif.wr_bus && !bif.rd_bus && !rd_seen) gap_seen = 1'b1;
      if (bif.rd_bus) begin
        rd_seen = 1'b1;
        if (!gap_seen) order_bad = 1'b1;
      end
      if (bif.resp_valid) begin
        n_resp++;
        rd_result = bif.resp_rdata;
        rd_err    = bif.resp_err;
      end
      if (bif.req_ready && n_resp == 1) begin
        @(posedge clk);
        #1 bif.req_valid = 1'b0;
      end
    end
    bif.req_valid = 1'b0;
    check("b2b_responses", 32'(n_resp), 32'd2);
    check("b2b_gap", {30'b0, gap_seen, order_bad}, 32'd2);
    check("b2b_read_data", rd_result, 32'hBEEF0001);
    check("b2b_read_err", {31'b0, rd_err}, 32'd0);

    // Reset asserted mid-ACCESS of a write, between clock edges.
    @(negedge clk);
    wait_ready();
    fc_at_cur = 0;
    bif.req_wr = 1'b1; bif.req_addr = 32'h1030; bif.req_size = 2'd2;
    bif.req_wdata = 32'h0F0F0F0F; bif.req_valid = 1'b1;
    @(posedge clk);
    #1 bif.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pre_wr_bus", {31'b0, bif.wr_bus}, 32'd1);
    check("rst_pre_data", data_bus, 32'h0F0F0F0F);
    #2;
    rst_n     = 1'b0;
    force_en  = 1'b1;
    force_val = 32'h12345600;
    #1;
    check("rst_async_wr_bus", {31'b0, bif.wr_bus}, 32'd0);
    check("rst_async_data_z", data_bus, 32'h12345600);
    check("rst_async_addr", bif.addr_bus, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_no_resp", {31'b0, bif.resp_valid}, 32'd0);
    rst_n    = 1'b1;
    force_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_after_%0d", c),
            {29'b0, bif.req_ready, bif.resp_valid, bif.wr_bus}, 32'd4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
